vga_sync_gen: RTL and testbench

//  Timing generator that sits directly upstream of the text/overlay renderer.

---
 rtl/vga_sync_gen.sv | 110 +++++++++++
 tb/tb_vga_sync_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: pixel-rate enable, sync and coordinate generator for the
// text/overlay renderer. Default timing is 640x480 @ 60 Hz from a clock
// DIV times faster than the pixel rate.
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous reset, active-low
//   p_tick     pixel enable, one clk wide every DIV clks (combinational decode)
//   pixel_x    current column, 0..H_TOTAL-1
//   pixel_y    current line, 0..V_TOTAL-1
//   video_on   high inside the visible area (registered)
//   hsync      horizontal sync, polarity per SYNC_POL (registered)
//   vsync      vertical sync, polarity per SYNC_POL (registered)
//   frame_end  one-clk pulse on the last pixel of a frame (combinational)
module vga_sync_gen #(
    parameter int unsigned DIV      = 4,
    parameter int unsigned H_DISP   = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_end
);

    localparam int unsigned CW       = 10;
    localparam int unsigned H_TOTAL  = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SS     = H_DISP + H_FP;
    localparam int unsigned H_SE     = H_SS + H_SYNC - 1;
    localparam int unsigned V_SS     = V_DISP + V_FP;
    localparam int unsigned V_SE     = V_SS + V_SYNC - 1;
    localparam logic        SYNC_ACT = (SYNC_POL != 0);

    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          h_last;
    logic          v_last;
    logic          hs_act;
    logic          vs_act;
    logic          vis;

    // Pixel-rate divider; with DIV = 1 every clk out of reset is a pixel.
    generate
        if (DIV > 1) begin : g_div
            localparam int unsigned DW = $clog2(DIV);
            logic [DW-1:0] div_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    div_cnt <= '0;
                end else if (div_cnt == DW'(DIV - 1)) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + DW'(1);
                end
            end

            assign p_tick = (div_cnt == DW'(DIV - 1));
        end else begin : g_nodiv
            assign p_tick = reset_n;
        end
    endgenerate

    // Next coordinates and the sync/visible decode of those coordinates.
    always_comb begin
        h_last = (pixel_x == CW'(H_TOTAL - 1));
        v_last = (pixel_y == CW'(V_TOTAL - 1));
        h_next = h_last ? '0 : pixel_x + CW'(1);
        v_next = pixel_y;
        if (h_last) begin
            v_next = v_last ? '0 : pixel_y + CW'(1);
        end
        hs_act = (h_next >= CW'(H_SS)) && (h_next <= CW'(H_SE));
        vs_act = (v_next >= CW'(V_SS)) && (v_next <= CW'(V_SE));
        vis    = (h_next < CW'(H_DISP)) && (v_next < CW'(V_DISP));
    end

    // Counters and registered sync outputs advance together so they stay aligned.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pixel_x  <= '0;
            pixel_y  <= '0;
            video_on <= 1'b0;
            hsync    <= ~SYNC_ACT;
            vsync    <= ~SYNC_ACT;
        end else if (p_tick) begin
            pixel_x  <= h_next;
            pixel_y  <= v_next;
            video_on <= vis;
            hsync    <= hs_act ? SYNC_ACT : ~SYNC_ACT;
            vsync    <= vs_act ? SYNC_ACT : ~SYNC_ACT;
        end
    end

    assign frame_end = p_tick && h_last && v_last;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: directed checks of vga_sync_gen. Three builds share one
// clock: default timing with DIV=4, default timing with DIV=1, and a tiny
// 16x10 frame with DIV=2 so whole frames fit in a short run.
module tb_vga_sync_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst4, rst1, rsts;

    logic       pt4, vo4, hs4, vs4, fe4;
    logic [9:0] x4, y4;
    logic       pt1, vo1, hs1, vs1, fe1;
    logic [9:0] x1, y1;
    logic       pts, vos, hss, vss, fes;
    logic [9:0] xs, ys;

    int n_total = 0;
    int n_bad   = 0;

    vga_sync_gen u_div4 (
        .clk(clk), .reset_n(rst4), .p_tick(pt4), .pixel_x(x4), .pixel_y(y4),
        .video_on(vo4), .hsync(hs4), .vsync(vs4), .frame_end(fe4)
    );

    vga_sync_gen #(.DIV(1)) u_div1 (
        .clk(clk), .reset_n(rst1), .p_tick(pt1), .pixel_x(x1), .pixel_y(y1),
        .video_on(vo1), .hsync(hs1), .vsync(vs1), .frame_end(fe1)
    );

    // 16 x 10 total: hsync on h 10..12, vsync on v 7..8, 8x6 visible.
    vga_sync_gen #(
        .DIV(2), .H_DISP(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_DISP(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) u_small (
        .clk(clk), .reset_n(rsts), .p_tick(pts), .pixel_x(xs), .pixel_y(ys),
        .video_on(vos), .hsync(hss), .vsync(vss), .frame_end(fes)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the next negedge at which the selected instance's p_tick is high.
    task automatic wait_tick(input int which, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            @(negedge clk);
            if ((which == 0 && pt4) || (which == 2 && pts)) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        bit found;
        int ticks, last, gap_err, xerr, hs_cnt, hs_first, vo_cnt, y0, pt_cnt;
        int t, fe_count, last_fe, gap, vid, vs_err, hs_err, pos_err;

        rst4 = 1'b0;
        rst1 = 1'b0;
        rsts = 1'b0;

        // Reset values while held in reset.
        repeat (10) @(negedge clk);
        check_eq("rst_tick", 32'(pt4), 32'd0);
        check_eq("rst_x", 32'(x4), 32'd0);
        check_eq("rst_y", 32'(y4), 32'd0);
        check_eq("rst_video", 32'(vo4), 32'd0);
        check_eq("rst_hsync", 32'(hs4), 32'd1);
        check_eq("rst_vsync", 32'(vs4), 32'd1);
        check_eq("rst_fend", 32'(fe4), 32'd0);
        check_eq("rst_tick_div1", 32'(pt1), 32'd0);

        // First tick on the 4th clk after release, x = 1 on the next.
        rst4 = 1'b1;
        @(negedge clk); check_eq("rel_tick_c1", 32'(pt4), 32'd0);
        @(negedge clk); check_eq("rel_tick_c2", 32'(pt4), 32'd0);
        @(negedge clk);
        check_eq("rel_tick_c3", 32'(pt4), 32'd1);
        check_eq("rel_x_c3", 32'(x4), 32'd0);
        check_eq("rel_video_c3", 32'(vo4), 32'd0);
        @(negedge clk);
        check_eq("rel_tick_c4", 32'(pt4), 32'd0);
        check_eq("rel_x_c4", 32'(x4), 32'd1);
        check_eq("rel_video_c4", 32'(vo4), 32'd1);

        // Pixel rate over 40 clks.
        ticks = 0; last = -1; gap_err = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (pt4) begin
                if (last >= 0 && (i - last) != 4) gap_err++;
                last = i;
                ticks++;
            end
        end
        check_eq("rate_ticks", 32'(ticks), 32'd10);
        check_eq("rate_gap_err", 32'(gap_err), 32'd0);

        // One full line from h = 0.
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (pt4 && x4 == 10'd0) found = 1'b1;
        end
        check_eq("line_start_found", 32'(found), 32'd1);
        y0 = int'(y4);
        xerr = 0; hs_cnt = 0; hs_first = -1; vo_cnt = 0;
        for (int p = 0; p < 800; p++) begin
            if (int'(x4) != p) xerr++;
            if (!hs4) begin
                if (hs_cnt == 0) hs_first = int'(x4);
                hs_cnt++;
            end
            if (vo4) vo_cnt++;
            wait_tick(0, ok);
            if (!ok) xerr++;
        end
        check_eq("line_x_seq_err", 32'(xerr), 32'd0);
        check_eq("line_hs_first", 32'(hs_first), 32'd656);
        check_eq("line_hs_count", 32'(hs_cnt), 32'd96);
        check_eq("line_video_count", 32'(vo_cnt), 32'd640);
        check_eq("line_wrap_x", 32'(x4), 32'd0);
        check_eq("line_wrap_y", 32'(y4), 32'(y0 + 1));

        // DIV = 1: one complete line in 800 clks.
        rst1 = 1'b1;
        #1;
        pt_cnt = 0; xerr = 0; hs_cnt = 0; hs_first = -1;
        for (int k = 0; k < 800; k++) begin
            if (pt1) pt_cnt++;
            if (int'(x1) != k) xerr++;
            if (!hs1) begin
                if (hs_cnt == 0) hs_first = k;
                hs_cnt++;
            end
            @(negedge clk);
        end
        check_eq("div1_tick_count", 32'(pt_cnt), 32'd800);
        check_eq("div1_x_seq_err", 32'(xerr), 32'd0);
        check_eq("div1_hs_first", 32'(hs_first), 32'd656);
        check_eq("div1_hs_count", 32'(hs_cnt), 32'd96);
        check_eq("div1_wrap_x", 32'(x1), 32'd0);
        check_eq("div1_wrap_y", 32'(y1), 32'd1);

        // Small build: two frames, frame_end spacing and sync windows.
        rsts = 1'b1;
        t = 0; fe_count = 0; last_fe = -1; gap = -1; vid = 0;
        vs_err = 0; hs_err = 0; pos_err = 0;
        while (fe_count < 2 && t < 400) begin
            wait_tick(2, ok);
            if (!ok) break;
            if ((vss == 1'b0) != (ys >= 10'd7 && ys <= 10'd8)) vs_err++;
            if ((hss == 1'b0) != (xs >= 10'd10 && xs <= 10'd12)) hs_err++;
            if (vos != (xs < 10'd8 && ys < 10'd6) && t != 0) vs_err++;
            if (fe_count == 1 && vos) vid++;
            if (fes) begin
                if (xs != 10'd15 || ys != 10'd9) pos_err++;
                if (fe_count > 0) gap = t - last_fe;
                last_fe = t;
                fe_count++;
            end
            t++;
        end
        check_eq("frame_tick_ok", 32'(ok), 32'd1);
        check_eq("frame_fe_count", 32'(fe_count), 32'd2);
        check_eq("frame_first_fe", 32'(gap >= 0 ? last_fe - gap : -1), 32'd159);
        check_eq("frame_fe_gap", 32'(gap), 32'd160);
        check_eq("frame_fe_pos_err", 32'(pos_err), 32'd0);
        check_eq("frame_vsync_err", 32'(vs_err), 32'd0);
        check_eq("frame_hsync_err", 32'(hs_err), 32'd0);
        check_eq("frame_video_count", 32'(vid), 32'd48);

        // Mid-frame reset between ticks at (5,4).
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (xs == 10'd5 && ys == 10'd4 && !pts) found = 1'b1;
        end
        check_eq("mid_found", 32'(found), 32'd1);
        check_eq("mid_video_before", 32'(vos), 32'd1);
        rsts = 1'b0;
        #1;
        check_eq("mid_x", 32'(xs), 32'd0);
        check_eq("mid_y", 32'(ys), 32'd0);
        check_eq("mid_video", 32'(vos), 32'd0);
        check_eq("mid_hsync", 32'(hss), 32'd1);
        check_eq("mid_vsync", 32'(vss), 32'd1);
        check_eq("mid_fend", 32'(fes), 32'd0);
        check_eq("mid_tick", 32'(pts), 32'd0);
        repeat (3) @(negedge clk);
        rsts = 1'b1;
        wait_tick(2, ok);
        check_eq("restart_tick_ok", 32'(ok), 32'd1);
        check_eq("restart_x0", 32'(xs), 32'd0);
        check_eq("restart_y0", 32'(ys), 32'd0);
        wait_tick(2, ok);
        check_eq("restart_x1", 32'(xs), 32'd1);
        check_eq("restart_y1", 32'(ys), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
